// File: rtl/l1_snoop_responder.sv
// Bus-side snoop responder for the L1 data cache: captures the snooped set,
// resolves HIT/HITM/NOHIT, writes back modified lines and returns the MESI-updated line.
package l1_snoop_pkg;

  typedef struct packed {
    logic [11:0] tag;
    logic [1:0]  mesi;
    logic [2:0]  lru;
    logic [31:0] data;
  } cache_line_t;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_E = 2'b10;
  localparam logic [1:0] MESI_M = 2'b11;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INVAL = 2'b10;
  localparam logic [1:0] OP_RWIM  = 2'b11;

  localparam logic [1:0] RES_HIT   = 2'b00;
  localparam logic [1:0] RES_HITM  = 2'b01;
  localparam logic [1:0] RES_NOHIT = 2'b10;

endpackage

module l1_snoop_responder
  import l1_snoop_pkg::*;
#(
  parameter int WAYS  = 8,
  parameter int TAG_W = 12,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         snoop_valid,
  output logic                         snoop_ready,
  input  logic [1:0]                   snoop_op,
  input  logic [TAG_W-1:0]             snoop_tag,
  input  cache_line_t [WAYS-1:0]       set_lines_i,
  output logic                         result_valid,
  output logic [1:0]                   snoop_result,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output cache_line_t                  wb_line,
  output logic                         upd_valid,
  output logic [WAY_W-1:0]             upd_way,
  output cache_line_t                  upd_line,
  output logic                         proto_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_RESPOND = 3'd2,
    S_WB      = 3'd3,
    S_UPDATE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [1:0]            r_op;
  logic [TAG_W-1:0]      r_tag;
  cache_line_t [WAYS-1:0] r_lines;

  logic [WAY_W-1:0]      r_way;
  cache_line_t           r_line;
  logic [1:0]            r_result;
  logic                  r_need_wb;
  logic                  r_chg;
  logic [1:0]            r_new_mesi;
  logic                  r_perr;

  logic [WAYS-1:0]       w_hit_vec;
  logic [WAY_W-1:0]      w_way;
  logic                  w_any_hit;
  logic                  w_multi;
  cache_line_t           w_sel_line;
  logic [1:0]            w_result;
  logic                  w_need_wb;
  logic                  w_chg;
  logic [1:0]            w_new_mesi;
  logic                  w_perr;
  cache_line_t           w_upd_line;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (snoop_valid) begin
          w_state_nxt = S_LOOKUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOOKUP: begin
        w_state_nxt = S_RESPOND;
      end
      S_RESPOND: begin
        if (r_need_wb) begin
          w_state_nxt = S_WB;
        end else if (r_chg) begin
          w_state_nxt = S_UPDATE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WB: begin
        if (wb_ready) begin
          w_state_nxt = S_UPDATE;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_UPDATE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Tag compare across captured ways; the lowest hitting way wins
  always_comb begin
    w_hit_vec = '0;
    w_way     = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if ((r_lines[i].tag == r_tag) && (r_lines[i].mesi != MESI_I)) begin
        w_hit_vec[i] = 1'b1;
        w_way        = WAY_W'(i);
      end else begin
        w_hit_vec[i] = 1'b0;
      end
    end
    w_any_hit  = |w_hit_vec;
    w_multi    = |(w_hit_vec & (w_hit_vec - WAYS'(1)));
    w_sel_line = r_lines[w_way];
  end

  // Snoop response and MESI transition for the selected way
  always_comb begin
    w_result   = RES_NOHIT;
    w_need_wb  = 1'b0;
    w_chg      = 1'b0;
    w_new_mesi = w_sel_line.mesi;
    w_perr     = w_multi;
    case (r_op)
      OP_READ: begin
        if (w_any_hit) begin
          case (w_sel_line.mesi)
            MESI_M: begin
              w_result   = RES_HITM;
              w_need_wb  = 1'b1;
              w_chg      = 1'b1;
              w_new_mesi = MESI_S;
            end
            MESI_E: begin
              w_result   = RES_HIT;
              w_chg      = 1'b1;
              w_new_mesi = MESI_S;
            end
            default: begin
              w_result   = RES_HIT;
            end
          endcase
        end else begin
          w_result = RES_NOHIT;
        end
      end
      OP_WRITE: begin
        // Another master writing a line we hold valid means coherence is broken
        if (w_any_hit) begin
          w_perr = 1'b1;
        end else begin
          w_perr = w_multi;
        end
      end
      OP_INVAL: begin
        if (w_any_hit) begin
          w_result   = RES_HIT;
          w_chg      = 1'b1;
          w_new_mesi = MESI_I;
          if (w_sel_line.mesi != MESI_S) begin
            w_perr = 1'b1;
          end else begin
            w_perr = w_multi;
          end
        end else begin
          w_result = RES_NOHIT;
        end
      end
      OP_RWIM: begin
        if (w_any_hit) begin
          w_chg      = 1'b1;
          w_new_mesi = MESI_I;
          if (w_sel_line.mesi == MESI_M) begin
            w_result  = RES_HITM;
            w_need_wb = 1'b1;
          end else begin
            w_result  = RES_HIT;
          end
        end else begin
          w_result = RES_NOHIT;
        end
      end
      default: begin
        w_result = RES_NOHIT;
      end
    endcase
  end

  // Request capture in IDLE and lookup result registration in LOOKUP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= 2'b00;
      r_tag      <= '0;
      r_lines    <= '0;
      r_way      <= '0;
      r_line     <= '0;
      r_result   <= RES_NOHIT;
      r_need_wb  <= 1'b0;
      r_chg      <= 1'b0;
      r_new_mesi <= MESI_I;
      r_perr     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && snoop_valid) begin
        r_op    <= snoop_op;
        r_tag   <= snoop_tag;
        r_lines <= set_lines_i;
      end
      if (r_state == S_LOOKUP) begin
        r_way      <= w_way;
        r_line     <= w_sel_line;
        r_result   <= w_result;
        r_need_wb  <= w_need_wb;
        r_chg      <= w_chg;
        r_new_mesi <= w_new_mesi;
        r_perr     <= w_perr;
      end
    end
  end

  // Updated line keeps tag, LRU and data; only MESI changes
  always_comb begin
    w_upd_line      = r_line;
    w_upd_line.mesi = r_new_mesi;
  end

  // Output decode from state
  always_comb begin
    snoop_ready  = 1'b0;
    result_valid = 1'b0;
    proto_err    = 1'b0;
    wb_valid     = 1'b0;
    wb_line      = '0;
    upd_valid    = 1'b0;
    upd_way      = '0;
    upd_line     = '0;
    case (r_state)
      S_IDLE: begin
        snoop_ready = ~rst;
      end
      S_RESPOND: begin
        result_valid = 1'b1;
        proto_err    = r_perr;
      end
      S_WB: begin
        wb_valid = 1'b1;
        wb_line  = r_line;
      end
      S_UPDATE: begin
        upd_valid = 1'b1;
        upd_way   = r_way;
        upd_line  = w_upd_line;
      end
      default: begin
        snoop_ready = 1'b0;
      end
    endcase
  end

  assign snoop_result = r_result;

endmodule

// File: tb/tb_l1_snoop_responder.sv
// Directed-vector bench for l1_snoop_responder with a queue scoreboard and a
// negedge monitor that checks every result, write-back and update strobe.
module tb_l1_snoop_responder;
  import l1_snoop_pkg::*;

  typedef struct packed {
    logic [2:0]  way;
    cache_line_t line;
  } upd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic snoop_valid = 1'b0;
  logic snoop_ready;
  logic [1:0] snoop_op = 2'b00;
  logic [11:0] snoop_tag = 12'h000;
  cache_line_t [7:0] set_lines_i = '0;
  logic result_valid;
  logic [1:0] snoop_result;
  logic wb_valid;
  logic wb_ready = 1'b0;
  cache_line_t wb_line;
  logic upd_valid;
  logic [2:0] upd_way;
  cache_line_t upd_line;
  logic proto_err;

  int checks = 0;
  int failures = 0;

  logic [2:0]  exp_res[$];
  cache_line_t exp_wb[$];
  upd_t        exp_upd[$];

  l1_snoop_responder #(.WAYS(8), .TAG_W(12)) dut (
    .clk(clk), .rst(rst),
    .snoop_valid(snoop_valid), .snoop_ready(snoop_ready),
    .snoop_op(snoop_op), .snoop_tag(snoop_tag), .set_lines_i(set_lines_i),
    .result_valid(result_valid), .snoop_result(snoop_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_line(wb_line),
    .upd_valid(upd_valid), .upd_way(upd_way), .upd_line(upd_line),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endfunction

  function automatic cache_line_t [7:0] base_lines();
    cache_line_t [7:0] l;
    for (int i = 0; i < 8; i++) begin
      l[i].tag  = 12'h100 + 12'(i);
      l[i].mesi = MESI_I;
      l[i].lru  = 3'(i);
      l[i].data = 32'hD000_0000 + 32'(i);
    end
    return l;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an output
  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_result", 64'(snoop_result), 64'h0bad);
        end else begin
          logic [2:0] e;
          e = exp_res.pop_front();
          chk("snoop_result", 64'(snoop_result), 64'(e[2:1]));
          chk("proto_err", 64'(proto_err), 64'(e[0]));
        end
      end else if (proto_err) begin
        chk("proto_err_outside_respond", 64'(proto_err), 64'h0);
      end
      if (wb_valid) begin
        if (exp_wb.size() == 0) begin
          chk("unexpected_wb", 64'(wb_line), 64'h0bad);
        end else begin
          chk("wb_line", 64'(wb_line), 64'(exp_wb[0]));
          if (wb_ready) begin
            void'(exp_wb.pop_front());
          end
        end
      end
      if (upd_valid) begin
        if (exp_upd.size() == 0) begin
          chk("unexpected_upd", 64'(upd_line), 64'h0bad);
        end else begin
          upd_t u;
          u = exp_upd.pop_front();
          chk("upd_way", 64'(upd_way), 64'(u.way));
          chk("upd_line", 64'(upd_line), 64'(u.line));
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!snoop_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(snoop_ready), 64'h1);
  endtask

  task automatic run_snoop(input logic [1:0] op, input logic [11:0] tag,
                           input cache_line_t [7:0] lines,
                           input logic [1:0] eres, input logic eperr,
                           input bit ewb, input bit eupd, input int eway,
                           input logic [1:0] emesi, input int stalls);
    upd_t u;
    wait_ready();
    exp_res.push_back({eres, eperr});
    if (ewb) exp_wb.push_back(lines[eway]);
    if (eupd) begin
      u.way       = 3'(eway);
      u.line      = lines[eway];
      u.line.mesi = emesi;
      exp_upd.push_back(u);
    end
    snoop_valid = 1'b1; snoop_op = op; snoop_tag = tag; set_lines_i = lines;
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    set_lines_i = ~lines;
    @(negedge clk);
    chk("busy_n1", 64'(snoop_ready), 64'h0);
    @(negedge clk);
    chk("result_valid_n2", 64'(result_valid), 64'h1);
    wb_ready = (stalls == 0);
    @(negedge clk);
    if (ewb) begin
      chk("wb_valid_n3", 64'(wb_valid), 64'h1);
      for (int s = 0; s < stalls; s++) begin
        @(posedge clk); #1;
        if (s == stalls - 1) wb_ready = 1'b1;
        @(negedge clk);
        chk("wb_valid_held", 64'(wb_valid), 64'h1);
      end
      @(posedge clk); #1;
      wb_ready = 1'b0;
      @(negedge clk);
      chk("upd_after_wb", 64'(upd_valid), 64'h1);
      @(negedge clk);
      chk("ready_after_wb", 64'(snoop_ready), 64'h1);
    end else if (eupd) begin
      wb_ready = 1'b0;
      chk("wb_absent_n3", 64'(wb_valid), 64'h0);
      chk("upd_valid_n3", 64'(upd_valid), 64'h1);
      @(negedge clk);
      chk("ready_n4", 64'(snoop_ready), 64'h1);
    end else begin
      wb_ready = 1'b0;
      chk("upd_absent_n3", 64'(upd_valid), 64'h0);
      chk("ready_n3", 64'(snoop_ready), 64'h1);
    end
  endtask

  initial begin
    cache_line_t [7:0] l;

    // Power-on reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(snoop_ready), 64'h0);
    chk("rst_result", 64'(snoop_result), 64'h2);
    chk("rst_strobes", 64'({result_valid, wb_valid, upd_valid, proto_err}), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(snoop_ready), 64'h1);

    // Reset in the middle of a stalled write-back
    l = base_lines();
    l[5].tag = 12'h3A5; l[5].mesi = MESI_M;
    wait_ready();
    exp_res.push_back({RES_HITM, 1'b0});
    exp_wb.push_back(l[5]);
    snoop_valid = 1'b1; snoop_op = OP_READ; snoop_tag = 12'h3A5; set_lines_i = l;
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("midwb_wb_valid", 64'(wb_valid), 64'h1);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midwb_strobes", 64'({result_valid, wb_valid, upd_valid, proto_err}), 64'h0);
    chk("midwb_result", 64'(snoop_result), 64'h2);
    chk("midwb_ready", 64'(snoop_ready), 64'h0);
    chk("midwb_upd_way", 64'(upd_way), 64'h0);
    chk("midwb_lines", 64'({wb_line, upd_line}), 64'h0);
    exp_wb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midwb_ready_after", 64'(snoop_ready), 64'h1);
    repeat (4) @(negedge clk);
    chk("midwb_no_upd", 64'(upd_valid), 64'h0);

    // READ of M line with three write-back stall cycles
    l = base_lines();
    l[5].tag = 12'h3A5; l[5].mesi = MESI_M;
    run_snoop(OP_READ, 12'h3A5, l, RES_HITM, 1'b0, 1'b1, 1'b1, 5, MESI_S, 3);

    // RWIM of E line
    l = base_lines();
    l[2].tag = 12'h222; l[2].mesi = MESI_E;
    run_snoop(OP_RWIM, 12'h222, l, RES_HIT, 1'b0, 1'b0, 1'b1, 2, MESI_I, 0);

    // READ where the only tag match is an invalid way
    l = base_lines();
    l[4].tag = 12'h155;
    run_snoop(OP_READ, 12'h155, l, RES_NOHIT, 1'b0, 1'b0, 1'b0, 0, MESI_I, 0);

    // INVALIDATE hitting two S ways
    l = base_lines();
    l[1].tag = 12'h0C3; l[1].mesi = MESI_S;
    l[6].tag = 12'h0C3; l[6].mesi = MESI_S;
    run_snoop(OP_INVAL, 12'h0C3, l, RES_HIT, 1'b1, 1'b0, 1'b1, 1, MESI_I, 0);

    // READ of E line, READ of S line, INVALIDATE of M line, RWIM of M line
    l = base_lines();
    l[7].tag = 12'h777; l[7].mesi = MESI_E;
    run_snoop(OP_READ, 12'h777, l, RES_HIT, 1'b0, 1'b0, 1'b1, 7, MESI_S, 0);
    l = base_lines();
    l[3].tag = 12'h033; l[3].mesi = MESI_S;
    run_snoop(OP_READ, 12'h033, l, RES_HIT, 1'b0, 1'b0, 1'b0, 3, MESI_S, 0);
    l = base_lines();
    l[4].tag = 12'h444; l[4].mesi = MESI_M;
    run_snoop(OP_INVAL, 12'h444, l, RES_HIT, 1'b1, 1'b0, 1'b1, 4, MESI_I, 0);
    l = base_lines();
    l[0].tag = 12'hFFF; l[0].mesi = MESI_M;
    run_snoop(OP_RWIM, 12'hFFF, l, RES_HITM, 1'b0, 1'b1, 1'b1, 0, MESI_I, 0);

    // WRITE hitting an S way with snoop_valid held through busy cycles
    l = base_lines();
    l[0].tag = 12'h0AB; l[0].mesi = MESI_S;
    wait_ready();
    exp_res.push_back({RES_NOHIT, 1'b1});
    exp_res.push_back({RES_NOHIT, 1'b1});
    snoop_valid = 1'b1; snoop_op = OP_WRITE; snoop_tag = 12'h0AB; set_lines_i = l;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_busy_n1", 64'(snoop_ready), 64'h0);
    @(negedge clk);
    chk("hold_result_n2", 64'(result_valid), 64'h1);
    @(negedge clk);
    chk("hold_ready_n3", 64'(snoop_ready), 64'h1);
    chk("hold_no_upd_n3", 64'(upd_valid), 64'h0);
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    @(negedge clk);
    chk("hold_n4", 64'({result_valid, snoop_ready}), 64'h0);
    @(negedge clk);
    chk("hold_second_result_n5", 64'(result_valid), 64'h1);
    @(negedge clk);
    chk("hold_ready_n6", 64'(snoop_ready), 64'h1);

    repeat (3) @(negedge clk);
    chk("res_queue_empty", 64'(exp_res.size()), 64'h0);
    chk("wb_queue_empty", 64'(exp_wb.size()), 64'h0);
    chk("upd_queue_empty", 64'(exp_upd.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1_snoop_responder.md
# l1_snoop_responder

Bus-side snoop responder for the L1 data cache: it is the other end of the processor/bus protocol, servicing snooped bus operations issued by other caches or L2 instead of processor requests. Per accepted snoop it captures the addressed set's ways, performs tag/MESI lookup, reports HIT/HITM/NOHIT, writes back a modified line when required, and returns the MESI-updated line to the data array. Sits between the bus/L2 model and the 8-way data cache array, alongside `processor`.

## Interface
- `WAYS`, 8, data cache associativity (way index width `$clog2(WAYS)`)
- `TAG_W`, 12, tag width; must match `cache_line_t.tag`
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `snoop_valid`  in  1  snoop request present
- `snoop_ready`  out  1  responder idle, can accept
- `snoop_op`  in  2  0 READ, 1 WRITE, 2 INVALIDATE, 3 RWIM
- `snoop_tag`  in  TAG_W  tag of snooped address
- `set_lines_i`  in  cache_line_t[WAYS]  current contents of the addressed set
- `result_valid`  out  1  one-cycle strobe, `snoop_result` valid
- `snoop_result`  out  2  2'b00 HIT, 2'b01 HITM, 2'b10 NOHIT
- `wb_valid`  out  1  modified line offered to bus
- `wb_ready`  in  1  bus accepts write-back
- `wb_line`  out  cache_line_t  line being written back
- `upd_valid`  out  1  one-cycle strobe, write `upd_line` into `upd_way`
- `upd_way`  out  $clog2(WAYS)  way to update
- `upd_line`  out  cache_line_t  updated line (MESI changed, tag/LRU unchanged)
- `proto_err`  out  1  one-cycle strobe on illegal snoop/state combination

## Operation
- MESI encoding: I 2'b00, S 2'b01, E 2'b10, M 2'b11. Hit = tag match AND MESI != I.
- Multiple hitting ways: lowest-index way is selected, `proto_err` pulses.
- States: IDLE, LOOKUP, RESPOND, WB, UPDATE.
- IDLE: `snoop_ready`=1. On `snoop_valid`: latch op, tag, all `set_lines_i` -> LOOKUP.
- LOOKUP: compare latched ways, register hit, way, prior MESI -> RESPOND.
- RESPOND: `result_valid`=1 for exactly one cycle, then per rule below.
- READ: M -> HITM, write-back, M->S; E -> HIT, E->S; S -> HIT, no change; miss -> NOHIT.
- RWIM: M -> HITM, write-back, M->I; E/S -> HIT, ->I; miss -> NOHIT.
- INVALIDATE: S -> HIT, ->I; E/M hit -> HIT, ->I, `proto_err`; miss -> NOHIT.
- WRITE: always NOHIT, no update; hit in any valid state -> `proto_err`.
- After RESPOND: write-back required -> WB; else MESI change -> UPDATE; else IDLE.
- WB: `wb_valid`=1, `wb_line` = captured line (MESI still M), held stable until `wb_ready`; then UPDATE.
- UPDATE: `upd_valid`=1 one cycle, `upd_line` = captured line with new MESI; -> IDLE.
- LRU bits are never modified by snoops.

## Timing
- Accept in cycle N (IDLE && `snoop_valid`); `set_lines_i` sampled only in cycle N.
- `result_valid` in cycle N+2.
- No write-back: `upd_valid` in N+3 (if change), `snoop_ready` again in N+3 (no change) or N+4.
- Write-back: WB entered N+3; `wb_ready` high in N+3 gives single WB cycle, `upd_valid` N+4, `snoop_ready` N+5; each extra stall cycle adds one.
- `snoop_valid` outside IDLE is ignored (no queuing); requester holds until `snoop_ready`.
- `proto_err` pulses in the RESPOND cycle.
- Reset (any state, incl. mid-WB): immediate return to IDLE; `result_valid`, `wb_valid`, `upd_valid`, `proto_err` = 0, `snoop_result` = 2'b10, `upd_way` = 0, `wb_line`/`upd_line` = 0; no update issued for aborted snoop. `snoop_ready` = 0 while `rst` high, 1 first cycle after release.

## Test plan
- Reset mid-WB (`wb_ready` held 0) -> all strobes 0 immediately, `snoop_result`=2'b10, no `upd_valid` after release, `snoop_ready`=1 next cycle.
- READ, way 5 tag 0x3A5 in M -> `snoop_result`=2'b01 at N+2, `wb_valid` with tag 0x3A5, `wb_ready` after 3 stall cycles -> `upd_valid` way 5, MESI 2'b01, LRU unchanged.
- RWIM, way 2 in E -> 2'b00 at N+2, no `wb_valid`, `upd_valid` N+3 way 2 MESI 2'b00.
- READ, matching tag only in an I way -> 2'b10, no `wb_valid`/`upd_valid`, `snoop_ready` N+3.
- INVALIDATE with tag hitting ways 1 and 6 (both S) -> `proto_err` pulse, way 1 updated to I, way 6 untouched.
- WRITE hitting way 0 in S -> 2'b10, `proto_err` pulse, no update; `snoop_valid` held through busy cycles accepted only once back in IDLE.
